// File: rtl/regfile_read_arbiter.sv
// regfile_read_arbiter
//   Shares the register file's two read ports among N_REQ operand requesters.
//   Grants one requester per cycle, round-robin. Drives the RF read addresses
//   and returns the read data tagged with the requester ID RD_LAT cycles later.
//
// Ports
//   i_CLK, i_RST          clock, synchronous active-high reset
//   i_req                 per-requester request, held until granted
//   i_req_addr_A/B        packed per-requester operand addresses
//   i_hold                suppresses new grants while high
//   o_gnt                 registered one-hot grant pulse
//   o_rdaddr_A/B          RF read addresses
//   i_rddata_A/B          RF read data, RD_LAT cycles after the address
//   o_rsp_valid/o_rsp_id  response strobe and owning requester
//   o_rsp_data_A/B        combinational pass of the RF read data
//   o_state_HEX0          debug {hold, in-flight, rr pointer}
module regfile_read_arbiter #(
   parameter int unsigned N_REQ  = 2,
   parameter int unsigned ADDR_W = 5,
   parameter int unsigned DATA_W = 32,
   parameter int unsigned RD_LAT = 1
) (
   input  logic                      i_CLK,
   input  logic                      i_RST,
   input  logic [N_REQ-1:0]          i_req,
   input  logic [N_REQ*ADDR_W-1:0]   i_req_addr_A,
   input  logic [N_REQ*ADDR_W-1:0]   i_req_addr_B,
   input  logic                      i_hold,
   output logic [N_REQ-1:0]          o_gnt,
   output logic [ADDR_W-1:0]         o_rdaddr_A,
   output logic [ADDR_W-1:0]         o_rdaddr_B,
   input  logic [DATA_W-1:0]         i_rddata_A,
   input  logic [DATA_W-1:0]         i_rddata_B,
   output logic                      o_rsp_valid,
   output logic [1:0]                o_rsp_id,
   output logic [DATA_W-1:0]         o_rsp_data_A,
   output logic [DATA_W-1:0]         o_rsp_data_B,
   output logic [3:0]                o_state_HEX0
);

   localparam int unsigned PTR_W  = 2;
   localparam int unsigned IDX_W  = 3;
   localparam int unsigned SRCH_W = 8;

   typedef enum logic {
      S_RUN  = 1'b0,
      S_HOLD = 1'b1
   } state_t;

   state_t              state_q, state_d;
   logic [PTR_W-1:0]    ptr_q, ptr_d;
   logic [N_REQ-1:0]    gnt_d;
   logic [ADDR_W-1:0]   rda_d, rdb_d;
   logic [PTR_W-1:0]    gnt_id_q, gnt_id_d;
   logic [RD_LAT-1:0]   vld_pipe_q;
   logic [PTR_W-1:0]    id_pipe_q [RD_LAT];

   logic                arb_en;
   logic [SRCH_W-1:0]   elig;
   logic                found;
   logic [PTR_W-1:0]    win;
   logic [IDX_W-1:0]    idx;

   // Round-robin search from ptr+1; a requester whose grant is visible now is masked
   always_comb begin
      elig  = SRCH_W'(i_req & ~o_gnt);
      found = 1'b0;
      win   = '0;
      idx   = '0;
      for (int unsigned i = 1; i <= N_REQ; i++) begin
         idx = IDX_W'(ptr_q) + IDX_W'(i);
         if (idx >= IDX_W'(N_REQ)) begin
            idx = idx - IDX_W'(N_REQ);
         end
         if (!found && elig[idx]) begin
            found = 1'b1;
            win   = PTR_W'(idx);
         end
      end
   end

   // Next state, grant and read-address selection
   always_comb begin
      state_d  = state_q;
      arb_en   = 1'b0;
      gnt_d    = '0;
      rda_d    = o_rdaddr_A;
      rdb_d    = o_rdaddr_B;
      ptr_d    = ptr_q;
      gnt_id_d = '0;

      case (state_q)
         S_RUN: begin
            if (i_hold) begin
               state_d = S_HOLD;
            end else begin
               arb_en = 1'b1;
            end
         end
         S_HOLD: begin
            if (!i_hold) begin
               state_d = S_RUN;
               arb_en  = 1'b1;
            end
         end
      endcase

      if (arb_en && found) begin
         ptr_d    = win;
         gnt_id_d = win;
         for (int unsigned k = 0; k < N_REQ; k++) begin
            if (win == PTR_W'(k)) begin
               gnt_d[k] = 1'b1;
               rda_d    = i_req_addr_A[k*ADDR_W +: ADDR_W];
               rdb_d    = i_req_addr_B[k*ADDR_W +: ADDR_W];
            end
         end
      end
   end

   // State, grant and response-tag registers
   always_ff @(posedge i_CLK) begin
      if (i_RST) begin
         state_q    <= S_RUN;
         ptr_q      <= PTR_W'(N_REQ - 1);
         o_gnt      <= '0;
         o_rdaddr_A <= '0;
         o_rdaddr_B <= '0;
         gnt_id_q   <= '0;
         vld_pipe_q <= '0;
         for (int unsigned k = 0; k < RD_LAT; k++) begin
            id_pipe_q[k] <= '0;
         end
      end else begin
         state_q       <= state_d;
         ptr_q         <= ptr_d;
         o_gnt         <= gnt_d;
         o_rdaddr_A    <= rda_d;
         o_rdaddr_B    <= rdb_d;
         gnt_id_q      <= gnt_id_d;
         // Stage 0 captures the grant visible this cycle
         vld_pipe_q[0] <= |o_gnt;
         id_pipe_q[0]  <= gnt_id_q;
         for (int unsigned k = 1; k < RD_LAT; k++) begin
            vld_pipe_q[k] <= vld_pipe_q[k-1];
            id_pipe_q[k]  <= id_pipe_q[k-1];
         end
      end
   end

   assign o_rsp_valid  = vld_pipe_q[RD_LAT-1];
   assign o_rsp_id     = id_pipe_q[RD_LAT-1];
   assign o_rsp_data_A = i_rddata_A;
   assign o_rsp_data_B = i_rddata_B;

   // In flight: from the grant cycle through the cycle its response is delivered
   assign o_state_HEX0 = {state_q == S_HOLD, (|o_gnt) | (|vld_pipe_q), ptr_q};

endmodule

// File: tb/tb_regfile_read_arbiter.sv
// Testbench for regfile_read_arbiter: three parameterisations
//   u0: N_REQ=2 RD_LAT=1 (directed table, fairness)
//   u1: N_REQ=2 RD_LAT=3 (latency, reset mid-flight)
//   u2: N_REQ=4 RD_LAT=2 (rotation plus randomized traffic against a queue model)
module tb_regfile_read_arbiter;

   logic clk;
   int   n_pass, n_total;

   initial clk = 1'b0;
   always #5 clk = ~clk;

   function automatic logic [31:0] rf_a(input logic [4:0] a);
      return 32'hA500_0000 | (32'(a) << 16) | 32'(a);
   endfunction

   function automatic logic [31:0] rf_b(input logic [4:0] a);
      return 32'hB600_0000 | (32'(a) << 8) | (32'(a) ^ 32'h1F);
   endfunction

   // ---------------- u0 ----------------
   logic        rst0, hold0, vld0;
   logic [1:0]  req0, gnt0, id0;
   logic [9:0]  aA0, aB0;
   logic [4:0]  rdA0, rdB0, pa0, pb0;
   logic [31:0] dA0, dB0, rspA0, rspB0;
   logic [3:0]  hex0;

   regfile_read_arbiter #(.N_REQ(2), .ADDR_W(5), .DATA_W(32), .RD_LAT(1)) u0 (
      .i_CLK(clk), .i_RST(rst0), .i_req(req0), .i_req_addr_A(aA0), .i_req_addr_B(aB0),
      .i_hold(hold0), .o_gnt(gnt0), .o_rdaddr_A(rdA0), .o_rdaddr_B(rdB0),
      .i_rddata_A(dA0), .i_rddata_B(dB0), .o_rsp_valid(vld0), .o_rsp_id(id0),
      .o_rsp_data_A(rspA0), .o_rsp_data_B(rspB0), .o_state_HEX0(hex0));

   always @(posedge clk) begin
      pa0 <= rdA0;
      pb0 <= rdB0;
   end
   assign dA0 = rf_a(pa0);
   assign dB0 = rf_b(pb0);

   // ---------------- u1 ----------------
   logic        rst1, hold1, vld1;
   logic [1:0]  req1, gnt1, id1;
   logic [9:0]  aA1, aB1;
   logic [4:0]  rdA1, rdB1;
   logic [4:0]  pa1 [3];
   logic [4:0]  pb1 [3];
   logic [31:0] dA1, dB1, rspA1, rspB1;
   logic [3:0]  hex1;

   regfile_read_arbiter #(.N_REQ(2), .ADDR_W(5), .DATA_W(32), .RD_LAT(3)) u1 (
      .i_CLK(clk), .i_RST(rst1), .i_req(req1), .i_req_addr_A(aA1), .i_req_addr_B(aB1),
      .i_hold(hold1), .o_gnt(gnt1), .o_rdaddr_A(rdA1), .o_rdaddr_B(rdB1),
      .i_rddata_A(dA1), .i_rddata_B(dB1), .o_rsp_valid(vld1), .o_rsp_id(id1),
      .o_rsp_data_A(rspA1), .o_rsp_data_B(rspB1), .o_state_HEX0(hex1));

   always @(posedge clk) begin
      pa1[0] <= rdA1; pa1[1] <= pa1[0]; pa1[2] <= pa1[1];
      pb1[0] <= rdB1; pb1[1] <= pb1[0]; pb1[2] <= pb1[1];
   end
   assign dA1 = rf_a(pa1[2]);
   assign dB1 = rf_b(pb1[2]);

   // ---------------- u2 ----------------
   logic        rst2, hold2, vld2;
   logic [3:0]  req2, gnt2;
   logic [1:0]  id2;
   logic [19:0] aA2, aB2;
   logic [4:0]  rdA2, rdB2;
   logic [4:0]  pa2 [2];
   logic [4:0]  pb2 [2];
   logic [31:0] dA2, dB2, rspA2, rspB2;
   logic [3:0]  hex2;

   regfile_read_arbiter #(.N_REQ(4), .ADDR_W(5), .DATA_W(32), .RD_LAT(2)) u2 (
      .i_CLK(clk), .i_RST(rst2), .i_req(req2), .i_req_addr_A(aA2), .i_req_addr_B(aB2),
      .i_hold(hold2), .o_gnt(gnt2), .o_rdaddr_A(rdA2), .o_rdaddr_B(rdB2),
      .i_rddata_A(dA2), .i_rddata_B(dB2), .o_rsp_valid(vld2), .o_rsp_id(id2),
      .o_rsp_data_A(rspA2), .o_rsp_data_B(rspB2), .o_state_HEX0(hex2));

   always @(posedge clk) begin
      pa2[0] <= rdA2; pa2[1] <= pa2[0];
      pb2[0] <= rdB2; pb2[1] <= pb2[0];
   end
   assign dA2 = rf_a(pa2[1]);
   assign dB2 = rf_b(pb2[1]);

   // ---------------- helpers ----------------
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
      n_total++;
      if (act !== exp) begin
         $display("FAIL %s: got 0x%0h, expected 0x%0h", nm, act, exp);
      end else begin
         n_pass++;
      end
   endtask

   typedef struct packed {
      logic [1:0] req;
      logic       hold;
      logic       aset;
      logic [1:0] gnt;
      logic [4:0] rda;
      logic [4:0] rdb;
      logic       vld;
      logic [1:0] id;
      logic [4:0] da;
      logic [4:0] db;
      logic       hb;
      logic [1:0] ptr;
   } vec_t;

   vec_t tbl [13];

   // Queue-based reference for u2
   typedef struct {
      int         due;
      int         id;
      logic [4:0] a;
      logic [4:0] b;
   } rsp_t;

   rsp_t       rq [$];
   rsp_t       r;
   int         m_ptr, m_gnt, nxt, c;
   logic       m_hold, hold_r, exp_v;
   logic [4:0] m_rda, m_rdb;
   bit         act [4];
   logic [4:0] ra [4];
   logic [4:0] rb [4];
   int         exp_seq [5];

   initial begin
      #1_000_000;
      $display("FAIL watchdog: got timeout, expected completion");
      $fatal(1, "watchdog");
   end

   initial begin
      n_pass = 0; n_total = 0;
      rst0 = 1'b1; rst1 = 1'b1; rst2 = 1'b1;
      req0 = '0; req1 = '0; req2 = '0;
      hold0 = 1'b0; hold1 = 1'b0; hold2 = 1'b0;
      aA0 = '0; aB0 = '0; aA1 = '0; aB1 = '0; aA2 = '0; aB2 = '0;
      tick(); tick();
      rst0 = 1'b0; rst1 = 1'b0; rst2 = 1'b0;

      // ---- u0 reset state and fairness ----
      check("u0 rst gnt", 64'(gnt0), 64'(0));
      check("u0 rst rdA", 64'(rdA0), 64'(0));
      check("u0 rst rdB", 64'(rdB0), 64'(0));
      check("u0 rst vld", 64'(vld0), 64'(0));
      check("u0 rst id", 64'(id0), 64'(0));
      check("u0 rst hex", 64'(hex0), 64'(4'h1));

      req0 = 2'b11; aA0 = {5'd4, 5'd0}; aB0 = {5'd5, 5'd1};
      tick();
      check("u0 fair first", 64'(gnt0), 64'(2'b01));
      req0 = 2'b00;
      tick();
      check("u0 fair gap", 64'(gnt0), 64'(2'b00));
      req0 = 2'b11;
      tick();
      check("u0 fair second", 64'(gnt0), 64'(2'b10));
      req0 = 2'b00;
      tick(); tick();

      rst0 = 1'b1;
      tick();
      rst0 = 1'b0;

      // ---- u0 directed table ----
      //            req    hold  aset  gnt    rdA    rdB    vld   id    dA     dB     hb    ptr
      tbl[0]  = '{2'b01, 1'b0, 1'b0, 2'b01, 5'd2, 5'd3, 1'b0, 2'd0, 5'd0, 5'd0, 1'b0, 2'd0};
      tbl[1]  = '{2'b01, 1'b0, 1'b0, 2'b00, 5'd2, 5'd3, 1'b1, 2'd0, 5'd2, 5'd3, 1'b0, 2'd0};
      tbl[2]  = '{2'b00, 1'b0, 1'b0, 2'b00, 5'd2, 5'd3, 1'b0, 2'd0, 5'd0, 5'd0, 1'b0, 2'd0};
      tbl[3]  = '{2'b11, 1'b0, 1'b1, 2'b10, 5'd4, 5'd5, 1'b0, 2'd0, 5'd0, 5'd0, 1'b0, 2'd1};
      tbl[4]  = '{2'b11, 1'b0, 1'b1, 2'b01, 5'd0, 5'd1, 1'b1, 2'd1, 5'd4, 5'd5, 1'b0, 2'd0};
      tbl[5]  = '{2'b11, 1'b0, 1'b1, 2'b10, 5'd4, 5'd5, 1'b1, 2'd0, 5'd0, 5'd1, 1'b0, 2'd1};
      tbl[6]  = '{2'b11, 1'b0, 1'b1, 2'b01, 5'd0, 5'd1, 1'b1, 2'd1, 5'd4, 5'd5, 1'b0, 2'd0};
      tbl[7]  = '{2'b11, 1'b1, 1'b1, 2'b00, 5'd0, 5'd1, 1'b1, 2'd0, 5'd0, 5'd1, 1'b1, 2'd0};
      tbl[8]  = '{2'b11, 1'b1, 1'b1, 2'b00, 5'd0, 5'd1, 1'b0, 2'd0, 5'd0, 5'd0, 1'b1, 2'd0};
      tbl[9]  = '{2'b11, 1'b1, 1'b1, 2'b00, 5'd0, 5'd1, 1'b0, 2'd0, 5'd0, 5'd0, 1'b1, 2'd0};
      tbl[10] = '{2'b11, 1'b0, 1'b1, 2'b10, 5'd4, 5'd5, 1'b0, 2'd0, 5'd0, 5'd0, 1'b0, 2'd1};
      tbl[11] = '{2'b00, 1'b0, 1'b1, 2'b00, 5'd4, 5'd5, 1'b1, 2'd1, 5'd4, 5'd5, 1'b0, 2'd1};
      tbl[12] = '{2'b00, 1'b0, 1'b1, 2'b00, 5'd4, 5'd5, 1'b0, 2'd0, 5'd0, 5'd0, 1'b0, 2'd1};

      for (int i = 0; i < 13; i++) begin
         req0  = tbl[i].req;
         hold0 = tbl[i].hold;
         aA0   = tbl[i].aset ? {5'd4, 5'd0} : {5'd4, 5'd2};
         aB0   = tbl[i].aset ? {5'd5, 5'd1} : {5'd5, 5'd3};
         tick();
         check($sformatf("u0 row%0d gnt", i), 64'(gnt0), 64'(tbl[i].gnt));
         check($sformatf("u0 row%0d rdA", i), 64'(rdA0), 64'(tbl[i].rda));
         check($sformatf("u0 row%0d rdB", i), 64'(rdB0), 64'(tbl[i].rdb));
         check($sformatf("u0 row%0d vld", i), 64'(vld0), 64'(tbl[i].vld));
         check($sformatf("u0 row%0d hex", i), 64'(hex0 & 4'hB), 64'({tbl[i].hb, 1'b0, tbl[i].ptr}));
         if (tbl[i].vld) begin
            check($sformatf("u0 row%0d id", i), 64'(id0), 64'(tbl[i].id));
            check($sformatf("u0 row%0d dA", i), 64'(rspA0), 64'(rf_a(tbl[i].da)));
            check($sformatf("u0 row%0d dB", i), 64'(rspB0), 64'(rf_b(tbl[i].db)));
         end
      end
      req0 = '0; hold0 = 1'b0;

      // ---- u1: RD_LAT=3 latency, then reset with reads in flight ----
      check("u1 rst hex", 64'(hex1), 64'(4'h1));
      req1 = 2'b01; aA1 = {5'd4, 5'd7}; aB1 = {5'd5, 5'd9};
      tick();
      check("u1 single gnt", 64'(gnt1), 64'(2'b01));
      check("u1 single rdA", 64'(rdA1), 64'(5'd7));
      check("u1 single rdB", 64'(rdB1), 64'(5'd9));
      req1 = 2'b00;
      tick();
      check("u1 lat+1 vld", 64'(vld1), 64'(0));
      tick();
      check("u1 lat+2 vld", 64'(vld1), 64'(0));
      tick();
      check("u1 lat+3 vld", 64'(vld1), 64'(1));
      check("u1 lat+3 id", 64'(id1), 64'(0));
      check("u1 lat+3 dA", 64'(rspA1), 64'(rf_a(5'd7)));
      check("u1 lat+3 dB", 64'(rspB1), 64'(rf_b(5'd9)));
      tick();
      check("u1 lat+4 vld", 64'(vld1), 64'(0));

      req1 = 2'b11; aA1 = {5'd4, 5'd2}; aB1 = {5'd5, 5'd3};
      tick();
      check("u1 mid gnt1", 64'(gnt1), 64'(2'b10));
      tick();
      check("u1 mid gnt2", 64'(gnt1), 64'(2'b01));
      req1 = 2'b00; rst1 = 1'b1;
      tick();
      rst1 = 1'b0;
      check("u1 post-rst gnt", 64'(gnt1), 64'(0));
      check("u1 post-rst rdA", 64'(rdA1), 64'(0));
      check("u1 post-rst rdB", 64'(rdB1), 64'(0));
      check("u1 post-rst vld", 64'(vld1), 64'(0));
      check("u1 post-rst id", 64'(id1), 64'(0));
      check("u1 post-rst hex", 64'(hex1), 64'(4'h1));
      for (int i = 0; i < 6; i++) begin
         tick();
         check($sformatf("u1 flushed vld c%0d", i), 64'(vld1), 64'(0));
      end

      // ---- u2: rotation of four requesters, then randomized traffic ----
      rst2 = 1'b1;
      tick();
      rst2 = 1'b0;
      check("u2 rst gnt", 64'(gnt2), 64'(0));
      check("u2 rst vld", 64'(vld2), 64'(0));
      check("u2 rst hex", 64'(hex2), 64'(4'h3));

      exp_seq = '{0, 1, 2, 3, 0};
      m_ptr = 3; m_gnt = -1; m_hold = 1'b0; m_rda = '0; m_rdb = '0;
      for (int k = 0; k < 4; k++) begin
         act[k] = 1'b1;
         ra[k]  = 5'(3 * k + 1);
         rb[k]  = 5'(31 - k);
      end

      for (int n = 0; n < 400; n++) begin
         if (n >= 6) begin
            for (int k = 0; k < 4; k++) begin
               if (act[k] && m_gnt == k) begin
                  if ($urandom % 2 == 0) begin
                     act[k] = 1'b0;
                  end else begin
                     ra[k] = 5'($urandom);
                     rb[k] = 5'($urandom);
                  end
               end else if (!act[k] && ($urandom % 10 < 4)) begin
                  act[k] = 1'b1;
                  ra[k]  = 5'($urandom);
                  rb[k]  = 5'($urandom);
               end
            end
         end
         hold_r = (n >= 6) && ($urandom % 8 == 0);
         for (int k = 0; k < 4; k++) begin
            req2[k]       = act[k];
            aA2[k*5 +: 5] = ra[k];
            aB2[k*5 +: 5] = rb[k];
         end
         hold2 = hold_r;

         // Model: next grant is the first active requester after the pointer,
         // skipping the one whose grant is currently visible; none while held.
         nxt = -1;
         if (!hold_r) begin
            for (int s = 1; s <= 4; s++) begin
               c = (m_ptr + s) % 4;
               if (nxt < 0 && act[c] && c != m_gnt) nxt = c;
            end
         end
         if (nxt >= 0) begin
            m_ptr = nxt;
            m_rda = ra[nxt];
            m_rdb = rb[nxt];
            r.due = n + 1 + 2;
            r.id  = nxt;
            r.a   = ra[nxt];
            r.b   = rb[nxt];
            rq.push_back(r);
         end
         m_gnt  = nxt;
         m_hold = hold_r;

         tick();

         check($sformatf("u2 c%0d gnt", n), 64'(gnt2), (m_gnt >= 0) ? (64'd1 << m_gnt) : 64'd0);
         if (n < 5) begin
            check($sformatf("u2 rot%0d", n), 64'(gnt2), 64'd1 << exp_seq[n]);
         end
         check($sformatf("u2 c%0d rdA", n), 64'(rdA2), 64'(m_rda));
         check($sformatf("u2 c%0d rdB", n), 64'(rdB2), 64'(m_rdb));
         check($sformatf("u2 c%0d hex", n), 64'(hex2 & 4'hB), 64'({m_hold, 1'b0, 2'(m_ptr)}));
         exp_v = (rq.size() > 0) && (rq[0].due == n + 1);
         check($sformatf("u2 c%0d vld", n), 64'(vld2), 64'(exp_v));
         if (exp_v) begin
            r = rq.pop_front();
            check($sformatf("u2 c%0d id", n), 64'(id2), 64'(r.id));
            check($sformatf("u2 c%0d dA", n), 64'(rspA2), 64'(rf_a(r.a)));
            check($sformatf("u2 c%0d dB", n), 64'(rspB2), 64'(rf_b(r.b)));
         end
      end

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule
